// File: rtl/jtag_data_reg.sv
// JTAG test-data register: capture/shift/update chain with a built-in 1-bit bypass stage.
// Latency: TDO is combinational from the selected stage. data_out and update_strobe are registered on the Update_DR edge.
// Backpressure: none. The TAP strobes are obeyed every TCK edge with priority Capture > Shift > Update.
module jtag_data_reg #(
  parameter int                 WIDTH      = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL  = '0,
  parameter bit                 STRICT_LEN = 1'b1,
  localparam int                CW         = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             TDI,
  output logic             TDO,
  input  logic             Capture_DR,
  input  logic             Shift_DR,
  input  logic             Update_DR,
  input  logic             Select,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             update_strobe,
  output logic             len_err,
  output logic [CW-1:0]    bit_count
);

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  logic [WIDTH-1:0] r_shift;
  logic             r_bypass;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data_out;
  logic             r_strobe;
  logic             r_len_err;

  logic             w_update;
  logic             w_len_ok;
  logic             w_accept;
  logic             w_reject;

  // An update only counts when neither higher-priority strobe is active and this DR is selected.
  assign w_update = Select && Update_DR && !Capture_DR && !Shift_DR;
  assign w_len_ok = !STRICT_LEN || (r_count == CNT_FULL);
  assign w_accept = w_update && w_len_ok;
  assign w_reject = w_update && !w_len_ok;

  // Capture/shift path. The bypass stage and the main chain hold each other's state across Select changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift  <= '0;
      r_bypass <= 1'b0;
      r_count  <= '0;
    end else if (Capture_DR) begin
      if (Select) begin
        r_shift <= data_in;
        r_count <= '0;
      end else begin
        r_bypass <= 1'b0;
      end
    end else if (Shift_DR) begin
      if (Select) begin
        r_shift <= {TDI, r_shift[WIDTH-1:1]};
        // Saturate so an over-length scan can never alias back to a legal length.
        if (r_count != CNT_MAX) begin
          r_count <= r_count + 1'b1;
        end
      end else begin
        r_bypass <= TDI;
      end
    end
  end

  // Update latch, one-cycle strobe and sticky length-error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= RESET_VAL;
      r_strobe   <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      r_strobe <= w_accept;
      if (w_accept) begin
        r_data_out <= r_shift;
        r_len_err  <= 1'b0;
      end else if (w_reject) begin
        r_len_err  <= 1'b1;
      end
    end
  end

  assign TDO           = Select ? r_shift[0] : r_bypass;
  assign data_out      = r_data_out;
  assign update_strobe = r_strobe;
  assign len_err       = r_len_err;
  assign bit_count     = r_count;

endmodule

// File: tb/tb_jtag_data_reg.sv
// Directed bench for jtag_data_reg (WIDTH=8, RESET_VAL=8'hA5, STRICT_LEN=1).
// Table of single-edge vectors for the main scan flow, then hand-written corner sequences.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_jtag_data_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       tdi, cap, shf, upd, sel;
  logic [7:0] din;
  logic       tdo, stb, err;
  logic [7:0] dout;
  logic [3:0] cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       cap, shf, upd, sel, tdi;
    logic [7:0] din;
    logic       tdo;
    logic [3:0] cnt;
    logic [7:0] dout;
    logic       stb, err;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  jtag_data_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .STRICT_LEN(1'b1)) dut (
    .clk(clk), .reset(reset), .TDI(tdi), .TDO(tdo),
    .Capture_DR(cap), .Shift_DR(shf), .Update_DR(upd), .Select(sel),
    .data_in(din), .data_out(dout), .update_strobe(stb),
    .len_err(err), .bit_count(cnt)
  );

  task automatic chk1(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check(input string name, input logic e_tdo, input logic [3:0] e_cnt,
                       input logic [7:0] e_dout, input logic e_stb, input logic e_err);
    chk1({name, ".tdo"},  {7'd0, tdo}, {7'd0, e_tdo});
    chk1({name, ".cnt"},  {4'd0, cnt}, {4'd0, e_cnt});
    chk1({name, ".dout"}, dout, e_dout);
    chk1({name, ".stb"},  {7'd0, stb}, {7'd0, e_stb});
    chk1({name, ".err"},  {7'd0, err}, {7'd0, e_err});
  endtask

  task automatic step(input logic c, input logic s, input logic u, input logic se,
                      input logic t, input logic [7:0] d);
    @(negedge clk);
    cap = c; shf = s; upd = u; sel = se; tdi = t; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic c, input logic s, input logic u, input logic t,
                     input logic [7:0] d, input logic e_tdo, input logic [3:0] e_cnt,
                     input logic [7:0] e_dout, input logic e_stb, input logic e_err);
    tbl.push_back('{c, s, u, 1'b1, t, d, e_tdo, e_cnt, e_dout, e_stb, e_err});
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] tdo_exp;

    reset = 1'b1; cap = 0; shf = 0; upd = 0; sel = 1; tdi = 0; din = 8'h00;
    #12;
    check("reset", 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Capture 3C, shift in 1,0,1,0,... -> 55, update.
    add(1,0,0,0,8'h3C, 0,0,8'hA5,0,0);
    pat = 8'h55; tdo_exp = 8'b1001_1110; // TDO after shift k = 3C[k] for k<8, then first TDI
    for (int k = 1; k <= 8; k++) begin
      add(0,1,0,pat[k-1],8'h00, tdo_exp[k-1], 4'(k), 8'hA5,0,0);
    end
    add(0,0,1,0,8'h00, 1,8,8'h55,1,0);
    add(0,0,0,0,8'h00, 1,8,8'h55,0,0);
    // Short scan (5 bits) is rejected, error is sticky.
    add(1,0,0,0,8'h81, 1,0,8'h55,0,0);
    for (int k = 1; k <= 5; k++) begin
      add(0,1,0,0,8'h00, 0, 4'(k), 8'h55,0,0);
    end
    add(0,0,1,0,8'h00, 0,5,8'h55,0,1);
    add(0,0,0,0,8'h00, 0,5,8'h55,0,1);
    // Full scan of C3 clears the error.
    add(1,0,0,0,8'h00, 0,0,8'h55,0,1);
    pat = 8'hC3;
    for (int k = 1; k <= 8; k++) begin
      add(0,1,0,pat[k-1],8'h00, (k == 8), 4'(k), 8'h55,0,1);
    end
    add(0,0,1,0,8'h00, 1,8,8'hC3,1,0);
    add(0,0,0,0,8'h00, 1,8,8'hC3,0,0);
    // Capture beats a simultaneous update.
    add(1,0,1,0,8'h18, 0,0,8'hC3,0,0);
    // Capture beats a simultaneous shift; F0 shifted out shows its bits.
    add(1,1,0,1,8'hF0, 0,0,8'hC3,0,0);
    add(0,1,0,0,8'h00, 0,1,8'hC3,0,0);
    add(0,1,0,0,8'h00, 0,2,8'hC3,0,0);
    add(0,1,0,0,8'h00, 0,3,8'hC3,0,0);
    add(0,1,0,0,8'h00, 1,4,8'hC3,0,0);
    add(0,0,1,0,8'h00, 1,4,8'hC3,0,1);

    foreach (tbl[i]) begin
      step(tbl[i].cap, tbl[i].shf, tbl[i].upd, tbl[i].sel, tbl[i].tdi, tbl[i].din);
      check($sformatf("vec%0d", i), tbl[i].tdo, tbl[i].cnt, tbl[i].dout, tbl[i].stb, tbl[i].err);
    end

    // Bypass: TDO source switches immediately, main chain holds.
    sel = 1'b0; #1;
    check("byp_sel", 0, 4, 8'hC3, 0, 1);
    step(0,1,0,0,1,8'h00); check("byp_sh1", 1, 4, 8'hC3, 0, 1);
    step(1,0,0,0,1,8'hFF); check("byp_cap", 0, 4, 8'hC3, 0, 1);
    step(0,1,0,0,1,8'h00); check("byp_a",   1, 4, 8'hC3, 0, 1);
    step(0,1,0,0,1,8'h00); check("byp_b",   1, 4, 8'hC3, 0, 1);
    step(0,1,0,0,0,8'h00); check("byp_c",   0, 4, 8'hC3, 0, 1);
    step(0,0,1,0,1,8'h00); check("byp_upd", 0, 4, 8'hC3, 0, 1);
    sel = 1'b1; #1;
    check("byp_back", 1, 4, 8'hC3, 0, 1);

    // Over-length scan: count saturates at 15, update rejected.
    step(1,0,0,1,0,8'h00); check("sat_cap", 0, 0, 8'hC3, 0, 1);
    for (int k = 1; k <= 17; k++) begin
      step(0,1,0,1,0,8'h00);
      check($sformatf("sat%0d", k), 0, (k > 15) ? 4'd15 : 4'(k), 8'hC3, 0, 1);
    end
    step(0,0,1,1,0,8'h00); check("sat_upd", 0, 15, 8'hC3, 0, 1);

    // Async reset in the middle of a scan.
    step(1,0,0,1,0,8'hFF); check("rst_cap", 1, 0, 8'hC3, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      step(0,1,0,1,0,8'h00);
    end
    #2 reset = 1'b1;
    #1 check("rst_mid", 0, 0, 8'hA5, 0, 0);
    @(negedge clk);
    reset = 1'b0; cap = 0; shf = 0; upd = 0;
    step(1,0,0,1,0,8'h00); check("rst_scan_cap", 0, 0, 8'hA5, 0, 0);
    pat = 8'h96;
    for (int k = 1; k <= 8; k++) begin
      step(0,1,0,1,pat[k-1],8'h00);
    end
    check("rst_scan_sh", 0, 8, 8'hA5, 0, 0);
    step(0,0,1,1,0,8'h00); check("rst_scan_upd", 0, 8, 8'h96, 1, 0);
    step(0,0,0,1,0,8'h00); check("rst_scan_idle", 0, 8, 8'h96, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
